// File: rtl/inst_fetch.sv
// Instruction fetch unit: fetch PC register, zero-latency ROM port and a DEPTH-entry prefetch FIFO.
// Optional misaligned-redirect fault detection is enabled with `define FETCH_ALIGN_CHECK_EN.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fault
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

    typedef enum logic [0:0] {StRun, StFault} state_e;

    state_e          state_q;
    logic [31:0]     fpc_q;
    logic [PtrW-1:0] head_q;
    logic [PtrW-1:0] tail_q;
    logic [PtrW:0]   count_q;
    logic [31:0]     buf_inst_q [DEPTH];
    logic [31:0]     buf_pc_q   [DEPTH];

    logic        run;
    logic        flush;
    logic        pop;
    logic        push;
    logic        misalign;
    logic [31:0] target_pc;

    assign target_pc = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign = (redirect_pc[1:0] != 2'b00);
    assign fault    = (state_q == StFault);
`else
    assign misalign = 1'b0;
    assign fault    = 1'b0;
`endif

    // Redirects are only honoured while fetching; in FAULT the buffer just drains.
    assign run        = (state_q == StRun);
    assign flush      = run & redirect;
    assign inst_valid = (count_q != '0);
    assign pop        = inst_valid & inst_ready;
    assign push       = run & ~redirect & ((count_q < FullCnt) | pop);

    assign rom_addr = fpc_q;
    assign inst     = buf_inst_q[head_q];
    assign inst_pc  = buf_pc_q[head_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StRun;
            fpc_q      <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            buf_inst_q <= '{default: '0};
            buf_pc_q   <= '{default: '0};
        end else if (flush) begin
            // A pop in the redirect cycle is dropped along with everything else.
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            if (misalign) begin
                state_q <= StFault;
            end else begin
                fpc_q <= target_pc;
            end
        end else begin
            if (push) begin
                buf_inst_q[tail_q] <= rom_data;
                buf_pc_q[tail_q]   <= fpc_q;
                tail_q             <= tail_q + PtrW'(1);
                fpc_q              <= fpc_q + 32'd4;
            end
            if (pop) begin
                head_q <= head_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (PtrW + 1)'(1);
                2'b01:   count_q <= count_q - (PtrW + 1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: constant vector table, hand-written corner sequences and a
// randomized run against a queue-based reference model.
module tb_inst_fetch;

    localparam logic [31:0] RstPc = 32'h0000_0000;
    localparam int          Depth = 2;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit AlignChk = 1'b1;
`else
    localparam bit AlignChk = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fault;

    int checks = 0;
    int errors = 0;

    inst_fetch #(
        .RESET_PC(RstPc),
        .DEPTH   (Depth)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    assign rom_data = rom_word(rom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit rd, input bit rdy, input logic [31:0] rpc);
        rst         = r;
        redirect    = rd;
        inst_ready  = rdy;
        redirect_pc = rpc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: FIFO of fetched {pc, word}, a fetch pointer and a halted flag.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;
    ent_t        mq[$];
    logic [31:0] mfpc;
    bit          mfault;

    task automatic model_check();
        chk("m_rom_addr", rom_addr, mfpc);
        chk("m_valid", inst_valid, mq.size() != 0);
        chk("m_fault", fault, mfault);
        if (mq.size() != 0) begin
            chk("m_inst_pc", inst_pc, mq[0].pc);
            chk("m_inst", inst, mq[0].ins);
        end
    endtask

    task automatic model_step(input bit r, input bit rd, input bit rdy, input logic [31:0] rpc);
        if (r) begin
            mq.delete();
            mfpc   = RstPc;
            mfault = 1'b0;
        end else if (!mfault && rd) begin
            mq.delete();
            if (AlignChk && rpc[1:0] != 2'b00) mfault = 1'b1;
            else mfpc = {rpc[31:2], 2'b00};
        end else begin
            if (mq.size() != 0 && rdy) void'(mq.pop_front());
            // Fetch whenever there is room once this cycle's consumption is accounted for.
            if (!mfault && mq.size() < Depth) begin
                mq.push_back('{mfpc, rom_word(mfpc)});
                mfpc = mfpc + 32'd4;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit rd, input bit rdy, input logic [31:0] rpc);
        drive(r, rd, rdy, rpc);
        model_check();
        model_step(r, rd, rdy, rpc);
        tick();
    endtask

    typedef struct {
        bit          rdy;
        bit          rd;
        logic [31:0] rpc;
        bit          v;
        logic [31:0] pc;
        logic [31:0] ra;
    } vec_t;
    vec_t tbl[17];

    initial begin
        // Back-pressure, release, redirect with full buffer, then redirect across the wrap.
        tbl[0]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         32'h4};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         32'h8};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         32'h8};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         32'h8};
        tbl[5]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         32'h8};
        tbl[6]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         32'hC};
        tbl[7]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         32'h10};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hC,         32'h14};
        tbl[9]  = '{1'b1, 1'b1, 32'h40,        1'b1, 32'h10,        32'h18};
        tbl[10] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h40};
        tbl[11] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h40,        32'h44};
        tbl[12] = '{1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 32'h44,        32'h48};
        tbl[13] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'hFFFF_FFF8};
        tbl[14] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC};
        tbl[15] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'h0};
        tbl[16] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         32'h4};

        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        chk("reset_valid", inst_valid, 1'b0);
        chk("reset_inst", inst, 32'h0);
        chk("reset_inst_pc", inst_pc, 32'h0);
        chk("reset_rom_addr", rom_addr, RstPc);
        chk("reset_fault", fault, 1'b0);

        for (int i = 0; i < 17; i++) begin
            drive(1'b0, tbl[i].rd, tbl[i].rdy, tbl[i].rpc);
            chk($sformatf("tbl%0d_valid", i), inst_valid, tbl[i].v);
            chk($sformatf("tbl%0d_rom_addr", i), rom_addr, tbl[i].ra);
            if (tbl[i].v) begin
                chk($sformatf("tbl%0d_inst_pc", i), inst_pc, tbl[i].pc);
                chk($sformatf("tbl%0d_inst", i), inst, rom_word(tbl[i].pc));
            end
            tick();
        end

        // Misaligned redirect after three streaming cycles (head pc 8, fpc 12).
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 32'h0);
            tick();
        end
        drive(1'b0, 1'b1, 1'b1, 32'h42);
        chk("mis_pre_pc", inst_pc, 32'h8);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h0);
        chk("mis_valid", inst_valid, 1'b0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("mis_fault", fault, 1'b1);
        chk("mis_rom_addr", rom_addr, 32'hC);
        tick();
        drive(1'b0, 1'b1, 1'b1, 32'h80);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h0);
        tick();
        chk("mis_ignored_valid", inst_valid, 1'b0);
        chk("mis_ignored_fault", fault, 1'b1);
        chk("mis_ignored_rom_addr", rom_addr, 32'hC);
`else
        chk("mis_fault", fault, 1'b0);
        chk("mis_rom_addr", rom_addr, 32'h40);
        tick();
        chk("mis_inst_pc", inst_pc, 32'h40);
        chk("mis_inst", inst, rom_word(32'h40));
        chk("mis_valid2", inst_valid, 1'b1);
`endif

        // Reset while the buffer holds two entries.
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        chk("full_valid", inst_valid, 1'b1);
        chk("full_rom_addr", rom_addr, 32'h8);
        drive(1'b1, 1'b1, 1'b1, 32'h100);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        chk("rst_mid_valid", inst_valid, 1'b0);
        chk("rst_mid_rom_addr", rom_addr, RstPc);
        chk("rst_mid_fault", fault, 1'b0);
        chk("rst_mid_inst", inst, 32'h0);
        chk("rst_mid_inst_pc", inst_pc, 32'h0);

        // Randomized run against the reference model.
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        model_step(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        for (int n = 0; n < 3000; n++) begin
            bit          r;
            bit          rd;
            bit          rdy;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 99) == 0);
            rd  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rpc = $urandom;
            if ($urandom_range(0, 7) != 0) rpc[1:0] = 2'b00;
            if ($urandom_range(0, 9) == 0) rpc[31:4] = 28'hFFF_FFFF;
            cyc(r, rd, rdy, rpc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset (word-aligned).
REQ-002 SHALL have parameter DEPTH, default 2, prefetch buffer entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rom_addr  output  32  byte address to instruction ROM read port (ROM indexes rom_addr[31:2], zero-latency combinational read).
REQ-006 SHALL have port rom_data  input  32  instruction word returned by ROM for rom_addr in the same cycle.
REQ-007 SHALL have port redirect  input  1  branch/jump taken; flush and refetch.
REQ-008 SHALL have port redirect_pc  input  32  new fetch address, sampled when redirect=1.
REQ-009 SHALL have port inst_valid  output  1  buffer head holds a valid instruction.
REQ-010 SHALL have port inst_ready  input  1  decode accepts head this cycle.
REQ-011 SHALL have port inst  output  32  instruction word at buffer head.
REQ-012 SHALL have port inst_pc  output  32  byte address of inst.
REQ-013 SHALL have port fault  output  1  misaligned-redirect fault (see Configuration).

Function
REQ-014 SHALL hold fetch PC register fpc; rom_addr SHALL equal fpc (registered, no combinational path from inputs).
REQ-015 SHALL define pop = inst_valid & inst_ready; push = state RUN & !redirect & (count<DEPTH | pop).
REQ-016 On push SHALL write {fpc, rom_data} at buffer tail and set fpc <= fpc+4 (32-bit wrap: 32'hFFFF_FFFC -> 32'h0000_0000).
REQ-017 On pop SHALL advance head; simultaneous push and pop at count==DEPTH SHALL keep count==DEPTH with no loss.
REQ-018 inst_valid SHALL equal (count!=0); inst/inst_pc SHALL be head entry, stable while inst_valid & !inst_ready.
REQ-019 Latency: push in cycle N makes the entry visible at inst/inst_valid in cycle N+1 if buffer was empty.
REQ-020 redirect SHALL take priority over push and pop: count <= 0, head/tail <= 0, fpc <= redirect_pc; a pop asserted in the redirect cycle SHALL be discarded (decode treats it as flushed).
REQ-021 FSM states: RUN (fetching), FAULT (fetch halted). RUN->FAULT only per REQ-027; FAULT exits only on rst.
REQ-022 In FAULT, push SHALL be 0; buffered entries SHALL still drain via pop; redirect SHALL be ignored.
REQ-023 Head/tail pointers SHALL wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.

Reset
REQ-024 On rst=1 at posedge: fpc=RESET_PC, count=0, head=tail=0, state=RUN, fault=0, all buffer entries=0.
REQ-025 During reset cycle outputs SHALL be: rom_addr=RESET_PC (next cycle), inst_valid=0, inst=0, inst_pc=0.
REQ-026 rst asserted mid-operation SHALL discard all buffered entries and any pending redirect.

Configuration
REQ-027 With FETCH_ALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]!=0 in RUN SHALL flush buffer, leave fpc unchanged, set fault=1, enter FAULT.
REQ-028 Without FETCH_ALIGN_CHECK_EN: redirect_pc[1:0] SHALL be forced to 2'b00, fault tied 0, FAULT state unreachable.

Verification
REQ-029 Reset then inst_ready=1 constantly, ROM word i = 32'h1000_0000+i -> from cycle 1, inst_pc=0,4,8,... one per cycle, inst matches.
REQ-030 inst_ready=0 for 5 cycles after reset -> count saturates at 2, inst_pc stays 0, rom_addr holds 8; then ready=1 -> pcs 0,4,8 consecutive, none lost/duplicated.
REQ-031 redirect=1, redirect_pc=32'h40 with buffer full, inst_ready=1 -> next cycle inst_valid=0, rom_addr=32'h40; cycle after, inst_pc=32'h40.
REQ-032 redirect_pc=32'hFFFF_FFF8, ready=1 -> inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-033 With FETCH_ALIGN_CHECK_EN: redirect_pc=32'h42 -> fault=1 next cycle, inst_valid=0, no further pushes, later redirect to 32'h80 ignored; without macro -> inst_pc=32'h40.
REQ-034 rst asserted while count=2 -> next cycle inst_valid=0, rom_addr=RESET_PC, fault=0.
